f_fetch_unit: RTL and testbench
===============================

# f_fetch_unit

Fetch-stage producer for the D-stage pipeline register. It owns the fetch PC and runs a request/ready handshake to instruction memory. It hands {PC, instruction, ExcCode, BD} to the D register one instruction at a time. It applies exception entry, eret and delayed-branch redirects, and discards in-flight fetches made stale by a redirect.

## Interface
- Parameters: none. Constants come from the shared package.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `advance`  in  1  D register accepts this cycle (its write enable)
- `req`  in  1  exception/interrupt taken (CP0 Req)
- `eret`  in  1  eret committing
- `epc`  in  32  eret target
- `br_valid`  in  1  one-cycle pulse: branch/jump leaving D
- `br_taken`  in  1  branch/jump redirects (qualified by br_valid)
- `br_target`  in  32  redirect target (qualified by br_valid & br_taken)
- `im_req`  out  1  fetch request
- `im_addr`  out  32  fetch address, word aligned
- `im_ready`  in  1  memory returns im_rdata this cycle
- `im_rdata`  in  32  fetched word
- `f_valid`  out  1  outputs below hold a deliverable instruction
- `f_pc`  out  32  PC of the instruction being delivered
- `f_instr`  out  32  instruction word; 0 when not valid or faulted
- `f_exc_code`  out  5  0, or AdEL (4) on a bad fetch address
- `f_bd`  out  1  delivered instruction is a delay slot

## Operation
- States: IDLE (reset), REQ (im_req=1, wait im_ready), HOLD (f_valid=1, wait advance), DROP (stale request outstanding; discard its data).
- Handoff: HOLD & advance & no redirect. On handoff, pc ← pending taken ? pending target : pc+4. The pending register is cleared.
- Pending register {jump, taken, target}:
  - Set on br_valid, with jump=1 for any branch or jump.
  - Consumed at the next handoff, which is the delay slot; f_bd = pending.jump during HOLD.
  - A second br_valid before consumption overwrites it.
- Redirect priority: req > eret > handoff.
  - req: pc ← 0x0000_4180.
  - eret: pc ← epc.
  - Both clear pending and drop f_valid the next cycle.
  - req/eret in REQ with im_ready=0 → DROP. In REQ with im_ready=1, the data is discarded → REQ. In HOLD → REQ.
- DROP: im_req=1 on the stale address until im_ready, then REQ on the new pc. A further redirect in DROP only updates pc.
- Address check is applied on entry to REQ with the new pc:
  - Bad address: pc[1:0]≠0 (and out of range, see Configuration).
  - A bad address issues no request. The block goes directly to HOLD with f_instr=0, f_exc_code=4, f_pc=bad pc.
- im_addr = pc in REQ, latched stale address in DROP. im_addr is stable while im_req=1 and im_ready=0.
- pc+4 wraps modulo 2^32. Any result is then subject to the address check.

## Timing
- Reset values: state IDLE, pc=0x0000_3000, pending cleared. Outputs: im_req=0, f_valid=0, f_pc=0x3000, f_instr=0, f_exc_code=0, f_bd=0.
- IDLE → REQ on the first clock after reset release.
- REQ with im_ready → HOLD next edge. f_instr is registered, so f_valid rises 1 cycle after im_ready.
- Handoff → REQ next edge. Peak throughput is 1 instruction per 2 cycles with zero-wait memory.
- Outputs are registered; im_req/im_addr are decoded from state and registers only, with no input-to-output combinational path.
- Reset asserted mid-fetch: everything returns to reset values immediately. A late im_ready is ignored while in IDLE.

## Configuration
- `F_FETCH_RANGE_CHECK_EN` defined: AdEL is also raised for pc outside [0x0000_3000, 0x0000_6FFC].
- Undefined: only misalignment raises AdEL; any aligned address is requested.

## Structure
- Shared package constants:
  - PC_RESET=0x3000, EXC_ENTRY=0x4180, IM_LO=0x3000, IM_HI=0x6FFC
  - EXC_ADEL=5'd4
  - 2-bit state encoding IDLE/REQ/HOLD/DROP
- One sub-module: `f_branch_pending`, the delay-slot pending register with set/consume/clear.

## Test plan
- Reset release, im_ready always 1 → im_addr 0x3000, 0x3004, 0x3008 on consecutive REQs. Each f_valid has f_exc_code=0 and f_bd=0.
- br_valid&br_taken, target 0x3100, while 0x3008 is in HOLD → handoff of 0x3008 with f_bd=1. Next im_addr = 0x3100, f_bd=0.
- req asserted in REQ with im_ready held 0 for 3 cycles → DROP. Stale data is discarded, then im_addr=0x4180, and f_pc=0x4180 is delivered.
- eret with epc=0x3002 → no im_req. HOLD with f_pc=0x3002, f_instr=0, f_exc_code=4.
- With the macro: eret to epc=0x8000 gives AdEL. Without the macro: im_addr=0x8000 is requested.
- Reset pulled low during DROP → all outputs at reset values asynchronously. Restart fetch at 0x3000.

Source files
------------

// File: rtl/f_fetch_unit_pkg.sv
// f_fetch_unit_pkg: shared constants, FSM encoding and fetch-address check for the fetch stage.
// The address check honours F_FETCH_RANGE_CHECK_EN (adds the instruction-memory window test).
package f_fetch_unit_pkg;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] IM_LO     = 32'h0000_3000;
    localparam logic [31:0] IM_HI     = 32'h0000_6FFC;
    localparam logic [4:0]  EXC_ADEL  = 5'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic        jump;
        logic        taken;
        logic [31:0] target;
    } pending_t;

    function automatic logic addr_bad(input logic [31:0] pc);
`ifdef F_FETCH_RANGE_CHECK_EN
        return (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
`else
        return pc[1:0] != 2'b00;
`endif
    endfunction

endpackage

// File: rtl/f_fetch_unit_branch_pending.sv
// f_branch_pending: delay-slot pending register {jump, taken, target}.
// Ports: clk, reset (async, active-low); set_i/taken_i/target_i capture a branch leaving D;
// consume_i empties it at the delay-slot handoff; clear_i empties it on exception/eret;
// jump_o/taken_o/target_o expose the stored record.
module f_branch_pending
    import f_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        set_i,
    input  logic        taken_i,
    input  logic [31:0] target_i,
    input  logic        consume_i,
    input  logic        clear_i,
    output logic        jump_o,
    output logic        taken_o,
    output logic [31:0] target_o
);

    pending_t pend_q, pend_d;

    // A new branch overrides consumption in the same cycle: its delay slot is still ahead.
    always_comb begin
        pend_d = clear_i ? '0 : set_i ? pending_t'({1'b1, taken_i, target_i}) : consume_i ? '0 : pend_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    assign jump_o   = pend_q.jump;
    assign taken_o  = pend_q.taken;
    assign target_o = pend_q.target;

endmodule

// File: rtl/f_fetch_unit.sv
// f_fetch_unit: fetch-stage producer feeding the D register over an im_req/im_ready handshake.
// Ports: clk, reset (async, active-low); advance (D accepts); req/eret/epc redirects;
// br_valid/br_taken/br_target delayed-branch record; im_req/im_addr/im_ready/im_rdata memory side;
// f_valid/f_pc/f_instr/f_exc_code/f_bd delivered instruction.
// Optional: F_FETCH_RANGE_CHECK_EN also raises AdEL for pc outside the instruction-memory window.
module f_fetch_unit
    import f_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic [31:0] im_rdata,
    output logic        f_valid,
    output logic [31:0] f_pc,
    output logic [31:0] f_instr,
    output logic [4:0]  f_exc_code,
    output logic        f_bd
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  stale_q, stale_d;
    logic [31:0]  instr_q, instr_d;
    logic [4:0]   exc_q, exc_d;

    logic        redir, handoff, go;
    logic [31:0] redir_pc;
    logic        pend_jump, pend_taken;
    logic [31:0] pend_target;

    assign redir    = req | eret;
    assign redir_pc = req ? EXC_ENTRY : epc;
    assign handoff  = (state_q == S_HOLD) && advance && !redir;

    f_branch_pending u_pending (
        .clk       (clk),
        .reset     (reset),
        .set_i     (br_valid),
        .taken_i   (br_taken),
        .target_i  (br_target),
        .consume_i (handoff),
        .clear_i   (redir),
        .jump_o    (pend_jump),
        .taken_o   (pend_taken),
        .target_o  (pend_target)
    );

    // go marks entry into a new fetch of pc_d; the address check then decides
    // between requesting it and faulting straight into HOLD.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stale_d = stale_q;
        instr_d = instr_q;
        exc_d   = exc_q;
        go      = 1'b0;
        case (state_q)
            S_IDLE: begin
                pc_d = redir ? redir_pc : pc_q;
                go   = 1'b1;
            end
            S_REQ: begin
                if (redir) begin
                    pc_d = redir_pc;
                    if (im_ready) begin
                        go = 1'b1;
                    end else begin
                        state_d = S_DROP;
                        stale_d = pc_q;
                    end
                end else if (im_ready) begin
                    state_d = S_HOLD;
                    instr_d = im_rdata;
                    exc_d   = '0;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    pc_d = redir_pc;
                    go   = 1'b1;
                end else if (advance) begin
                    pc_d = pend_taken ? pend_target : pc_q + 32'd4;
                    go   = 1'b1;
                end
            end
            S_DROP: begin
                pc_d = redir ? redir_pc : pc_q;
                go   = im_ready;
            end
            default: state_d = S_IDLE;
        endcase
        if (go) begin
            state_d = addr_bad(pc_d) ? S_HOLD : S_REQ;
            if (addr_bad(pc_d)) begin
                instr_d = '0;
                exc_d   = EXC_ADEL;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RESET;
            stale_q <= PC_RESET;
            instr_q <= '0;
            exc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stale_q <= stale_d;
            instr_q <= instr_d;
            exc_q   <= exc_d;
        end
    end

    // In DROP the memory still owes data for the old address, so that address stays on the bus.
    assign im_req     = (state_q == S_REQ) || (state_q == S_DROP);
    assign im_addr    = (state_q == S_DROP) ? stale_q : pc_q;
    assign f_valid    = state_q == S_HOLD;
    assign f_pc       = pc_q;
    assign f_instr    = f_valid ? instr_q : '0;
    assign f_exc_code = f_valid ? exc_q : '0;
    assign f_bd       = f_valid & pend_jump;

endmodule

// File: tb/tb_f_fetch_unit.sv
// tb_f_fetch_unit: directed scenarios plus randomized run against a transaction-level model.
module tb_f_fetch_unit;

    logic        clk, reset, advance, req, eret, br_valid, br_taken, im_ready;
    logic [31:0] epc, br_target, im_rdata, im_addr, f_pc, f_instr;
    logic        im_req, f_valid, f_bd;
    logic [4:0]  f_exc_code;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    f_fetch_unit dut (
        .clk(clk), .reset(reset), .advance(advance), .req(req), .eret(eret), .epc(epc),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
        .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready), .im_rdata(im_rdata),
        .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr), .f_exc_code(f_exc_code), .f_bd(f_bd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic exp_bad(input logic [31:0] a);
`ifdef F_FETCH_RANGE_CHECK_EN
        return (a[1:0] != 2'b00) || (a < 32'h3000) || (a > 32'h6FFC);
`else
        return a[1:0] != 2'b00;
`endif
    endfunction

    assign im_rdata = mem_word(im_addr);

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({im_req, f_valid, f_bd} !== 3'b000) $display("FAIL reset_ctl: got %b want 000", {im_req, f_valid, f_bd});
        else pass_cnt++;
        total_cnt++;
        if (f_pc !== 32'h3000) $display("FAIL reset_pc: got %h want 00003000", f_pc);
        else pass_cnt++;
        total_cnt++;
        if ({f_instr, f_exc_code} !== 37'd0) $display("FAIL reset_data: got %h/%h want 0/0", f_instr, f_exc_code);
        else pass_cnt++;
    endtask

    task automatic test_sequential;
        logic [31:0] aq[$];
        logic [31:0] got;
        int n_del = 0;
        reset = 1'b1;
        im_ready = 1'b1;
        for (int c = 0; c < 20 && n_del < 3; c++) begin
            @(negedge clk);
            if (im_req) aq.push_back(im_addr);
            advance = 1'b0;
            if (f_valid) begin
                total_cnt++;
                if (f_pc !== 32'h3000 + 32'(4 * n_del)) $display("FAIL seq_pc: got %h want %h", f_pc, 32'h3000 + 32'(4 * n_del));
                else pass_cnt++;
                total_cnt++;
                if ({f_exc_code, f_bd} !== 6'd0) $display("FAIL seq_exc_bd: got %h/%b want 0/0", f_exc_code, f_bd);
                else pass_cnt++;
                total_cnt++;
                if (f_instr !== mem_word(32'h3000 + 32'(4 * n_del))) $display("FAIL seq_instr: got %h want %h", f_instr, mem_word(32'h3000 + 32'(4 * n_del)));
                else pass_cnt++;
                n_del++;
                advance = n_del < 3;
            end
        end
        total_cnt++;
        if (n_del != 3) $display("FAIL seq_count: got %0d want 3", n_del);
        else pass_cnt++;
        total_cnt++;
        if (aq.size() != 3) $display("FAIL seq_nreq: got %0d want 3", aq.size());
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            got = (i < aq.size()) ? aq[i] : 32'hxxxx_xxxx;
            total_cnt++;
            if (got !== 32'h3000 + 32'(4 * i)) $display("FAIL seq_addr%0d: got %h want %h", i, got, 32'h3000 + 32'(4 * i));
            else pass_cnt++;
        end
    endtask

    task automatic test_branch;
        br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h3100;
        @(negedge clk);
        br_valid = 1'b0; br_taken = 1'b0;
        total_cnt++;
        if ({f_valid, f_bd, f_pc} !== {2'b11, 32'h3008}) $display("FAIL br_slot: got v=%b bd=%b pc=%h want v=1 bd=1 pc=00003008", f_valid, f_bd, f_pc);
        else pass_cnt++;
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        total_cnt++;
        if ({im_req, f_valid, im_addr} !== {2'b10, 32'h3100}) $display("FAIL br_addr: got req=%b v=%b addr=%h want req=1 v=0 addr=00003100", im_req, f_valid, im_addr);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({f_valid, f_bd, f_pc} !== {2'b10, 32'h3100}) $display("FAIL br_target: got v=%b bd=%b pc=%h want v=1 bd=0 pc=00003100", f_valid, f_bd, f_pc);
        else pass_cnt++;
        total_cnt++;
        if (f_instr !== mem_word(32'h3100)) $display("FAIL br_instr: got %h want %h", f_instr, mem_word(32'h3100));
        else pass_cnt++;
    endtask

    task automatic test_req_drop;
        advance = 1'b1; im_ready = 1'b0;
        @(negedge clk);
        advance = 1'b0;
        total_cnt++;
        if ({im_req, im_addr} !== {1'b1, 32'h3104}) $display("FAIL drop_pre: got req=%b addr=%h want req=1 addr=00003104", im_req, im_addr);
        else pass_cnt++;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({im_req, f_valid, im_addr} !== {2'b10, 32'h3104}) $display("FAIL drop_stale%0d: got req=%b v=%b addr=%h want req=1 v=0 addr=00003104", i, im_req, f_valid, im_addr);
            else pass_cnt++;
            if (i < 2) @(negedge clk);
        end
        im_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({im_req, f_valid, im_addr} !== {2'b10, 32'h4180}) $display("FAIL drop_exc_addr: got req=%b v=%b addr=%h want req=1 v=0 addr=00004180", im_req, f_valid, im_addr);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({f_valid, f_pc, f_instr, f_exc_code} !== {1'b1, 32'h4180, mem_word(32'h4180), 5'd0}) $display("FAIL drop_exc_deliver: got v=%b pc=%h instr=%h exc=%0d want v=1 pc=00004180 instr=%h exc=0", f_valid, f_pc, f_instr, f_exc_code, mem_word(32'h4180));
        else pass_cnt++;
    endtask

    task automatic test_eret_bad;
        eret = 1'b1; epc = 32'h3002;
        @(negedge clk);
        eret = 1'b0;
        total_cnt++;
        if ({im_req, f_valid, f_pc} !== {2'b01, 32'h3002}) $display("FAIL eret_mis_ctl: got req=%b v=%b pc=%h want req=0 v=1 pc=00003002", im_req, f_valid, f_pc);
        else pass_cnt++;
        total_cnt++;
        if ({f_instr, f_exc_code} !== {32'd0, 5'd4}) $display("FAIL eret_mis_exc: got instr=%h exc=%0d want instr=0 exc=4", f_instr, f_exc_code);
        else pass_cnt++;
        eret = 1'b1; epc = 32'h8000;
        @(negedge clk);
        eret = 1'b0;
`ifdef F_FETCH_RANGE_CHECK_EN
        total_cnt++;
        if ({im_req, f_valid, f_pc, f_exc_code} !== {2'b01, 32'h8000, 5'd4}) $display("FAIL eret_range: got req=%b v=%b pc=%h exc=%0d want req=0 v=1 pc=00008000 exc=4", im_req, f_valid, f_pc, f_exc_code);
        else pass_cnt++;
`else
        total_cnt++;
        if ({im_req, f_valid, im_addr} !== {2'b10, 32'h8000}) $display("FAIL eret_range: got req=%b v=%b addr=%h want req=1 v=0 addr=00008000", im_req, f_valid, im_addr);
        else pass_cnt++;
`endif
    endtask

    task automatic test_reset_in_drop;
        im_ready = 1'b0; eret = 1'b1; epc = 32'h3200;
        @(negedge clk);
        eret = 1'b0; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        total_cnt++;
        if ({im_req, f_valid} !== 2'b10) $display("FAIL rstdrop_pre: got req=%b v=%b want req=1 v=0", im_req, f_valid);
        else pass_cnt++;
        #2 reset = 1'b0;
        #1;
        total_cnt++;
        if ({im_req, f_valid, f_bd, f_pc, f_instr, f_exc_code} !== {3'b000, 32'h3000, 32'd0, 5'd0}) $display("FAIL rstdrop_async: got req=%b v=%b bd=%b pc=%h instr=%h exc=%0d want all reset values", im_req, f_valid, f_bd, f_pc, f_instr, f_exc_code);
        else pass_cnt++;
        im_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({im_req, f_valid} !== 2'b00) $display("FAIL rstdrop_hold: got req=%b v=%b want 0/0", im_req, f_valid);
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({im_req, im_addr} !== {1'b1, 32'h3000}) $display("FAIL rstdrop_restart: got req=%b addr=%h want req=1 addr=00003000", im_req, im_addr);
        else pass_cnt++;
    endtask

    // Model tracks only program order: the PC that must be delivered next and the
    // pending delay-slot record; cycle timing is left entirely to the DUT.
    task automatic test_random;
        logic [31:0] exp_pc = 32'h3000;
        logic        pend_v = 1'b0, pend_t = 1'b0;
        logic [31:0] pend_tgt = '0;
        logic        prev_req = 1'b0, prev_rdy = 1'b0;
        logic [31:0] prev_addr = '0;
        logic        adv, rq, er, bv, bt, rdy;
        logic [31:0] ep, tgt;
        int          r, idle = 0, deliv = 0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_req && !prev_rdy && im_req) begin
                total_cnt++;
                if (im_addr !== prev_addr) $display("FAIL rnd_addr_stable: got %h want %h", im_addr, prev_addr);
                else pass_cnt++;
            end
            adv = $urandom_range(0, 2) != 0;
            rq  = $urandom_range(0, 59) == 0;
            er  = !rq && ($urandom_range(0, 59) == 0);
            r   = int'($urandom_range(0, 9));
            ep  = (r == 0) ? 32'h8000 : 32'h3000 + 4 * $urandom_range(0, 1023) + ((r == 1) ? $urandom_range(1, 3) : 0);
            bv  = $urandom_range(0, 5) == 0;
            bt  = 1'($urandom_range(0, 1));
            tgt = 32'h3000 + 4 * $urandom_range(0, 1023);
            rdy = im_req && ($urandom_range(0, 2) != 0);
            advance = adv; req = rq; eret = er; epc = ep;
            br_valid = bv; br_taken = bt; br_target = tgt; im_ready = rdy;
            if (f_valid && adv && !(rq || er)) begin
                deliv++;
                idle = 0;
                total_cnt++;
                if ({f_pc, f_bd} !== {exp_pc, pend_v}) $display("FAIL rnd_pc_bd: got pc=%h bd=%b want pc=%h bd=%b", f_pc, f_bd, exp_pc, pend_v);
                else pass_cnt++;
                total_cnt++;
                if ({f_instr, f_exc_code} !== (exp_bad(exp_pc) ? {32'd0, 5'd4} : {mem_word(exp_pc), 5'd0})) $display("FAIL rnd_data: pc=%h got instr=%h exc=%0d want bad=%b instr=%h", exp_pc, f_instr, f_exc_code, exp_bad(exp_pc), mem_word(exp_pc));
                else pass_cnt++;
                exp_pc = (pend_v && pend_t) ? pend_tgt : exp_pc + 32'd4;
                pend_v = 1'b0;
            end else begin
                idle++;
            end
            if (bv) {pend_v, pend_t, pend_tgt} = {1'b1, bt, tgt};
            if (rq || er) begin
                exp_pc = rq ? 32'h4180 : ep;
                pend_v = 1'b0;
            end
            prev_req = im_req; prev_rdy = rdy; prev_addr = im_addr;
            if (idle > 200) begin
                total_cnt++;
                $display("FAIL rnd_watchdog: got no delivery for %0d cycles want at most 200", idle);
                break;
            end
            @(negedge clk);
        end
        advance = 1'b0; req = 1'b0; eret = 1'b0; br_valid = 1'b0; im_ready = 1'b0;
        total_cnt++;
        if (deliv < 100) $display("FAIL rnd_throughput: got %0d deliveries want at least 100", deliv);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b0; advance = 1'b0; req = 1'b0; eret = 1'b0; epc = '0;
        br_valid = 1'b0; br_taken = 1'b0; br_target = '0; im_ready = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_req_drop();
        test_eret_bad();
        test_reset_in_drop();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
